// File: rtl/rs_dec_pkg.sv
// Shared constants and types for the RS(204,188) decoder scheduler.
// Holds default geometry, pacer state encoding and the byte type.
package rs_dec_pkg;

  localparam int N_DEF     = 204;
  localparam int K_DEF     = 188;
  localparam int GAP_DEF   = 6;
  localparam int CNT_W_DEF = 16;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } pacer_st_t;

endpackage

// File: rtl/rs_ce_pacer.sv
// Chip-enable pacer: one CE pulse per accepted byte, then an idle gap.
// Ports: clk/reset, en, in_valid/in_data in; in_ready, accept, dec_ce,
// dec_byte (held between accepts) and idle out.
module rs_ce_pacer
  import rs_dec_pkg::*;
#(
  parameter int GAP = GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       accept,
  output logic       dec_ce,
  output logic [7:0] dec_byte,
  output logic       idle
);

  localparam int GW = $clog2(GAP + 1);
  // GAP state lasts GAP cycles; with the IDLE cycle that gives
  // GAP+1 low CE cycles and a CE-to-CE spacing of GAP+2.
  localparam logic [GW-1:0] GAP_END = GW'(GAP - 1);

  pacer_st_t     state;
  pacer_st_t     state_nx;
  logic [GW-1:0] gap_cnt;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt  <= '0;
      dec_byte <= '0;
    end else begin
      if (state == ST_ISSUE)
        gap_cnt <= '0;
      else if (state == ST_GAP && gap_cnt != GAP_END)
        gap_cnt <= gap_cnt + GW'(1);
      if (accept)
        dec_byte <= in_data;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_END) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    dec_ce   = 1'b0;
    idle     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = en;
        idle     = 1'b1;
      end
      ST_ISSUE: dec_ce = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/rs_dec_sched.sv
// Input pacer and output framer around the RS(204,188) decoder core.
// Ports: valid/ready byte input, dec_ce/dec_byte to the core, core
// strobes in, framed 188-byte output, block counters, frame_err, busy.
module rs_dec_sched
  import rs_dec_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K     = K_DEF,
  parameter int GAP   = GAP_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             dec_ce,
  output logic [7:0]       dec_byte,
  input  logic [7:0]       dec_out_byte,
  input  logic             dec_ceo,
  input  logic             dec_valid_out,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic [CNT_W-1:0] blk_in_cnt,
  output logic [CNT_W-1:0] blk_out_cnt,
  output logic             frame_err,
  output logic             busy
);

  localparam int PW = $clog2(N);
  localparam int OW = $clog2(K);
  localparam logic [PW-1:0] IN_END  = PW'(N - 1);
  localparam logic [OW-1:0] OUT_END = OW'(K - 1);

  logic          accept;
  logic          pacer_idle;
  logic          out_stb;
  logic [PW-1:0] in_pos;
  logic [OW-1:0] out_pos;

  rs_ce_pacer #(.GAP(GAP)) u_pacer (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .accept   (accept),
    .dec_ce   (dec_ce),
    .dec_byte (dec_byte),
    .idle     (pacer_idle)
  );

  assign busy    = ~pacer_idle | (in_pos != '0);
  assign out_stb = dec_ceo & dec_valid_out;

  // An early in_last resyncs to a new codeword without counting it;
  // a missing in_last at the final byte is flagged but still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_pos     <= '0;
      blk_in_cnt <= '0;
      frame_err  <= 1'b0;
    end else if (accept) begin
      if (in_last && in_pos != IN_END) begin
        frame_err <= 1'b1;
        in_pos    <= '0;
      end else if (in_pos == IN_END) begin
        in_pos     <= '0;
        blk_in_cnt <= blk_in_cnt + CNT_W'(1);
        if (!in_last) frame_err <= 1'b1;
      end else begin
        in_pos <= in_pos + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_pos     <= '0;
      blk_out_cnt <= '0;
    end else begin
      out_valid <= out_stb;
      out_sof   <= out_stb && out_pos == '0;
      out_eof   <= out_stb && out_pos == OUT_END;
      if (out_stb) begin
        out_data <= dec_out_byte;
        if (out_pos == OUT_END) begin
          out_pos     <= '0;
          blk_out_cnt <= blk_out_cnt + CNT_W'(1);
        end else begin
          out_pos <= out_pos + OW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_dec_sched.sv
// Self-checking bench for rs_dec_sched: timestamp-based reference
// model checked every cycle, plus directed literal checkpoints.
module tb_rs_dec_sched;
  import rs_dec_pkg::*;

  localparam int N   = 204;
  localparam int K   = 188;
  localparam int GAP = 6;

  logic        clk = 0;
  logic        reset = 1;
  logic        en = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  in_data = 0;
  logic        in_last = 0;
  logic        dec_ce;
  logic [7:0]  dec_byte;
  logic [7:0]  dec_out_byte = 0;
  logic        dec_ceo = 0;
  logic        dec_valid_out = 0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic [15:0] blk_in_cnt;
  logic [15:0] blk_out_cnt;
  logic        frame_err;
  logic        busy;

  rs_dec_sched #(.N(N), .K(K), .GAP(GAP), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .dec_ce(dec_ce), .dec_byte(dec_byte),
    .dec_out_byte(dec_out_byte), .dec_ceo(dec_ceo),
    .dec_valid_out(dec_valid_out),
    .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof),
    .blk_in_cnt(blk_in_cnt), .blk_out_cnt(blk_out_cnt),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: CE time and pacer-free time derived from the
  // accept cycle; positions and counters by plain arithmetic.
  int          free_at, ce_at;
  logic [7:0]  m_dbyte, m_od;
  int          m_pos, m_opos;
  logic [15:0] m_bin, m_bout;
  bit          m_ferr, m_ov, m_sof, m_eof;

  always @(negedge clk) begin
    if (reset) begin
      free_at = 0; ce_at = -1; m_dbyte = 0; m_pos = 0;
      m_bin = 0; m_ferr = 0; m_opos = 0; m_bout = 0;
      m_ov = 0; m_od = 0; m_sof = 0; m_eof = 0;
    end
    chk("in_ready", in_ready, en && cyc >= free_at);
    chk("dec_ce", dec_ce, cyc == ce_at);
    chk("dec_byte", dec_byte, m_dbyte);
    chk("busy", busy, cyc < free_at || m_pos != 0);
    chk("blk_in_cnt", blk_in_cnt, m_bin);
    chk("frame_err", frame_err, m_ferr);
    chk("blk_out_cnt", blk_out_cnt, m_bout);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_sof", out_sof, m_sof);
      chk("out_eof", out_eof, m_eof);
    end
    if (!reset) begin
      if (in_valid && en && cyc >= free_at) begin
        ce_at   = cyc + 1;
        free_at = cyc + GAP + 2;
        m_dbyte = in_data;
        if (in_last && m_pos != N - 1) begin
          m_ferr = 1; m_pos = 0;
        end else if (m_pos == N - 1) begin
          m_pos = 0; m_bin++;
          if (!in_last) m_ferr = 1;
        end else begin
          m_pos++;
        end
      end
      m_ov = dec_ceo && dec_valid_out;
      if (m_ov) begin
        m_od  = dec_out_byte;
        m_sof = (m_opos == 0);
        m_eof = (m_opos == K - 1);
        m_opos = (m_opos + 1) % K;
        if (m_eof) m_bout++;
      end
    end
  end

  bit rec = 0;
  int ce_q[$];
  int sof_n = 0, eof_n = 0;
  always @(negedge clk) begin
    if (rec && dec_ce) ce_q.push_back(cyc);
    if (rec && out_valid && out_sof) sof_n++;
    if (rec && out_valid && out_eof) eof_n++;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int w = 0;
    in_valid = 1; in_data = d; in_last = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++w > 60) begin
        tests++; fails++;
        $display("FAIL send_timeout act=noaccept exp=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0; in_last = 0;
  endtask

  initial begin
    int mn, mx;
    tick(3);
    reset = 0;
    tick(2);

    // Reset mid-stream after 50 bytes
    for (int i = 0; i < 50; i++) send(8'(i + 16), 0);
    reset = 1;
    #1;
    chk("rst_ce_now", dec_ce, 0);
    tick(2);
    @(negedge clk);
    chk("rst_blk_in", blk_in_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_dbyte", dec_byte, 0);
    tick(1);
    reset = 0;
    tick(2);

    // One clean codeword, CE period measured
    rec = 1; ce_q.delete();
    for (int i = 0; i < N; i++) send(8'(i), i == N - 1);
    tick(12);
    rec = 0;
    chk("ce_count", ce_q.size(), N);
    mn = 1000; mx = 0;
    for (int i = 1; i < ce_q.size(); i++) begin
      if (ce_q[i] - ce_q[i-1] < mn) mn = ce_q[i] - ce_q[i-1];
      if (ce_q[i] - ce_q[i-1] > mx) mx = ce_q[i] - ce_q[i-1];
    end
    chk("ce_period_min", mn, 8);
    chk("ce_period_max", mx, 8);
    @(negedge clk);
    chk("cw_blk_in", blk_in_cnt, 1);
    chk("cw_ferr", frame_err, 0);
    chk("cw_dbyte", dec_byte, 8'hCB);
    chk("cw_busy", busy, 0);

    // Early in_last at byte 100
    for (int i = 0; i <= 100; i++) send(8'($urandom), i == 100);
    tick(10);
    @(negedge clk);
    chk("early_ferr", frame_err, 1);
    chk("early_blk_in", blk_in_cnt, 1);
    chk("early_busy", busy, 0);
    for (int i = 0; i < 30; i++) send(8'($urandom), 0);
    tick(10);
    @(negedge clk);
    chk("ferr_sticky", frame_err, 1);

    // en dropped one cycle after an accept
    tick(1);
    rec = 1; ce_q.delete();
    send(8'hA5, 0);
    tick(1);
    en = 0; in_valid = 1; in_data = 8'h5A;
    tick(20);
    @(negedge clk);
    chk("en_low_ready", in_ready, 0);
    chk("en_low_ce_cnt", ce_q.size(), 1);
    tick(1);
    en = 1;
    send(8'h5A, 0);
    tick(3);
    rec = 0;
    chk("en_back_ce_cnt", ce_q.size(), 2);
    chk("en_back_dbyte", dec_byte, 8'h5A);

    // Randomized mixed traffic
    for (int i = 0; i < 3000; i++) begin
      en            = ($urandom % 8) != 0;
      in_valid      = $urandom % 2;
      in_data       = 8'($urandom);
      in_last       = ($urandom % 64) == 0;
      dec_ceo       = $urandom % 2;
      dec_valid_out = ($urandom % 4) != 0;
      dec_out_byte  = 8'($urandom);
      tick(1);
    end
    en = 1; in_valid = 0; in_last = 0;
    dec_ceo = 0; dec_valid_out = 0;
    tick(10);

    // Output framing: 376 valid strobes with idle/invalid fillers
    reset = 1;
    tick(2);
    reset = 0;
    tick(2);
    rec = 1; sof_n = 0; eof_n = 0;
    for (int i = 0; i < 2 * K; i++) begin
      dec_ceo = 1; dec_valid_out = 1; dec_out_byte = 8'(i);
      tick(1);
      case ($urandom % 4)
        0: begin
          dec_ceo = 1; dec_valid_out = 0;
          dec_out_byte = 8'hEE;
          tick(1);
        end
        1: begin
          dec_ceo = 0; dec_valid_out = 1;
          tick(1);
        end
        default: ;
      endcase
    end
    dec_ceo = 0; dec_valid_out = 0;
    tick(3);
    rec = 0;
    @(negedge clk);
    chk("out_blk_cnt", blk_out_cnt, 2);
    chk("out_sof_n", sof_n, 2);
    chk("out_eof_n", eof_n, 2);
    chk("out_last_data", out_data, 8'(2 * K - 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
